// File: rtl/othello_pkg.sv
// Shared definitions for the Othello controller and datapath: board geometry,
// cell codes and the controller state encoding.
package othello_pkg;

    localparam int BOARD_DIM   = 10;
    localparam int BOARD_CELLS = BOARD_DIM * BOARD_DIM;

    localparam logic [3:0] LAST_RC   = 4'(BOARD_DIM - 1);
    localparam logic [6:0] LAST_CELL = 7'(BOARD_CELLS - 1);
    localparam logic [3:0] MID_LO    = 4'd4;
    localparam logic [3:0] MID_HI    = 4'd5;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;
    localparam logic [1:0] CELL_WALL  = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_WAIT_GO = 2'd1,
        ST_RUN     = 2'd2,
        ST_END     = 2'd3
    } state_t;

endpackage

// File: rtl/othello_control_board_init_gen.sv
// Maps a padded-board row/col to the cell code loaded at power-up:
// wall border, four centre stones, everything else empty.
module board_init_gen
    import othello_pkg::*;
(
    input  logic [3:0] row_i,
    input  logic [3:0] col_i,
    output logic [1:0] data_o
);

    logic onBorder;
    logic whiteStart;
    logic blackStart;

    assign onBorder   = (row_i == 4'd0) || (row_i == LAST_RC) ||
                        (col_i == 4'd0) || (col_i == LAST_RC);
    assign whiteStart = ((row_i == MID_LO) && (col_i == MID_LO)) ||
                        ((row_i == MID_HI) && (col_i == MID_HI));
    assign blackStart = ((row_i == MID_LO) && (col_i == MID_HI)) ||
                        ((row_i == MID_HI) && (col_i == MID_LO));

    always_comb begin
        data_o = CELL_EMPTY;
        if (onBorder) begin
            data_o = CELL_WALL;
        end else if (whiteStart) begin
            data_o = CELL_WHITE;
        end else if (blackStart) begin
            data_o = CELL_BLACK;
        end
    end

endmodule

// File: rtl/othello_control.sv
// Othello game controller: loads the padded board after reset, then hands
// player moves to the datapath and tracks whose turn it is.
module othello_control
    import othello_pkg::*;
#(
    parameter int TIMEOUT = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic [5:0] switches,
    input  logic       ack,
    input  logic       game_end,
    output logic [5:0] addr,
    output logic       enable,
    output logic       player,
    output logic [6:0] init_addr,
    output logic [1:0] init_data,
    output logic       init_wren,
    output logic       init_busy,
    output logic       rejected,
    output logic       over
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic [6:0] idx_q;
    logic [3:0] row_q;
    logic [3:0] col_q;
    logic [7:0] timer_q;
    logic       goPrev_q;
    logic [5:0] addr_q;
    logic       enable_q;
    logic       player_q;
    logic       rejected_q;
    logic       over_q;
    logic       goRise;

    assign goRise = go && !goPrev_q;

    board_init_gen u_initGen (
        .row_i  (row_q),
        .col_i  (col_q),
        .data_o (init_data)
    );

    // game_end takes priority over ack and timeout; ack beats a same-cycle timeout
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_INIT;
            idx_q      <= 7'd0;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            timer_q    <= 8'd0;
            goPrev_q   <= 1'b0;
            addr_q     <= 6'd0;
            enable_q   <= 1'b0;
            player_q   <= 1'b0;
            rejected_q <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            goPrev_q   <= go;
            rejected_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (idx_q == LAST_CELL) begin
                        idx_q   <= 7'd0;
                        row_q   <= 4'd0;
                        col_q   <= 4'd0;
                        state_q <= ST_WAIT_GO;
                    end else begin
                        idx_q <= idx_q + 7'd1;
                        if (col_q == LAST_RC) begin
                            col_q <= 4'd0;
                            row_q <= row_q + 4'd1;
                        end else begin
                            col_q <= col_q + 4'd1;
                        end
                    end
                end
                ST_WAIT_GO: begin
                    if (game_end) begin
                        over_q  <= 1'b1;
                        state_q <= ST_END;
                    end else if (goRise) begin
                        addr_q   <= switches;
                        enable_q <= 1'b1;
                        timer_q  <= 8'd0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (game_end) begin
                        enable_q <= 1'b0;
                        over_q   <= 1'b1;
                        state_q  <= ST_END;
                    end else if (ack) begin
                        enable_q <= 1'b0;
                        player_q <= ~player_q;
                        state_q  <= ST_WAIT_GO;
                    end else if (timer_q == TIMER_LAST) begin
                        enable_q   <= 1'b0;
                        rejected_q <= 1'b1;
                        state_q    <= ST_WAIT_GO;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                ST_END: begin
                    enable_q <= 1'b0;
                    over_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign addr      = addr_q;
    assign enable    = enable_q;
    assign player    = player_q;
    assign rejected  = rejected_q;
    assign over      = over_q;
    assign init_addr = idx_q;
    assign init_wren = (state_q == ST_INIT);
    assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_othello_control.sv
// Self-checking bench for othello_control: board load contents, move
// handshake, timeout, go edge detection, end of game and reset restart.
module tb_othello_control;

    localparam int TIMEOUT = 200;

    logic       clock = 1'b0;
    logic       reset;
    logic       go;
    logic [5:0] switches;
    logic       ack;
    logic       game_end;
    logic [5:0] addr;
    logic       enable;
    logic       player;
    logic [6:0] init_addr;
    logic [1:0] init_data;
    logic       init_wren;
    logic       init_busy;
    logic       rejected;
    logic       over;

    int   assertCount = 0;
    int   failCount   = 0;
    logic expPlayer;

    typedef struct {
        int         idx;
        logic [1:0] data;
    } initVec_t;

    typedef struct {
        logic [5:0] sw;
        int         ackAt;
        int         expEn;
        int         expRej;
        bit         toggle;
    } moveVec_t;

    initVec_t initTab[7];
    moveVec_t moveTab[6];

    always #5 clock = ~clock;

    othello_control #(.TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .go        (go),
        .switches  (switches),
        .ack       (ack),
        .game_end  (game_end),
        .addr      (addr),
        .enable    (enable),
        .player    (player),
        .init_addr (init_addr),
        .init_data (init_data),
        .init_wren (init_wren),
        .init_busy (init_busy),
        .rejected  (rejected),
        .over      (over)
    );

    // Reference cell code for a padded-board index, from the board rules
    function automatic logic [1:0] cellModel(input int idx);
        int r;
        int c;
        r = idx / 10;
        c = idx % 10;
        if (r == 0 || r == 9 || c == 0 || c == 9) return 2'b11;
        if ((r == 4 && c == 4) || (r == 5 && c == 5)) return 2'b10;
        if ((r == 4 && c == 5) || (r == 5 && c == 4)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        @(negedge clock);
        reset    = 1'b1;
        go       = 1'b0;
        ack      = 1'b0;
        game_end = 1'b0;
        switches = 6'd0;
        repeat (2) @(negedge clock);
    endtask

    // Called with reset high at a falling edge; releases it and watches the load
    task automatic runInit(input string tag);
        logic [1:0] cap [100];
        int seqErr;
        int dataErr;
        seqErr  = 0;
        dataErr = 0;
        reset   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (init_addr !== 7'(k) || init_wren !== 1'b1 || init_busy !== 1'b1) seqErr++;
            cap[k] = init_data;
            if (init_data !== cellModel(k)) dataErr++;
            @(negedge clock);
        end
        checkOutput({tag, "_seq"}, seqErr, 0);
        checkOutput({tag, "_data"}, dataErr, 0);
        checkOutput({tag, "_busy_low"}, {31'd0, init_busy}, 0);
        checkOutput({tag, "_wren_low"}, {31'd0, init_wren}, 0);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("%s_cell%0d", tag, initTab[i].idx),
                        {30'd0, cap[initTab[i].idx]}, {30'd0, initTab[i].data});
        end
    endtask

    // One go pulse, then ack on RUN cycle ackAt (0 = never)
    task automatic applyStimulus(input logic [5:0] sw, input int ackAt,
                                 output int enCycles, output int rejPulses);
        enCycles  = 0;
        rejPulses = 0;
        @(negedge clock);
        switches = sw;
        go       = 1'b1;
        @(negedge clock);
        go = 1'b0;
        for (int c = 1; c <= TIMEOUT + 5; c++) begin
            if (rejected) rejPulses++;
            if (!enable) break;
            enCycles++;
            ack = (c == ackAt);
            @(negedge clock);
            ack = 1'b0;
        end
        repeat (2) begin
            @(negedge clock);
            if (rejected) rejPulses++;
        end
    endtask

    task automatic doMove(input string tag, input logic [5:0] sw, input int ackAt,
                          input int expEn, input int expRej, input bit toggle);
        int enCycles;
        int rejPulses;
        applyStimulus(sw, ackAt, enCycles, rejPulses);
        if (toggle) expPlayer = ~expPlayer;
        checkOutput({tag, "_addr"}, {26'd0, addr}, {26'd0, sw});
        checkOutput({tag, "_enable_cycles"}, enCycles, expEn);
        checkOutput({tag, "_rejected"}, rejPulses, expRej);
        checkOutput({tag, "_player"}, {31'd0, player}, {31'd0, expPlayer});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   entries;
        logic prevEn;
        int   n;
        int   enHigh;
        int   ackAt;
        int   expEn;
        int   expRej;
        logic [5:0] sw;

        initTab[0] = '{0,  2'b11};
        initTab[1] = '{44, 2'b10};
        initTab[2] = '{45, 2'b01};
        initTab[3] = '{54, 2'b01};
        initTab[4] = '{55, 2'b10};
        initTab[5] = '{11, 2'b00};
        initTab[6] = '{99, 2'b11};

        moveTab[0] = '{6'o34, 6,   6,   0, 1'b1};
        moveTab[1] = '{6'o00, 0,   200, 1, 1'b0};
        moveTab[2] = '{6'o77, 1,   1,   0, 1'b1};
        moveTab[3] = '{6'o12, 200, 200, 0, 1'b1};
        moveTab[4] = '{6'o53, 201, 200, 1, 1'b0};
        moveTab[5] = '{6'o45, 2,   2,   0, 1'b1};

        reset = 1'b1; go = 1'b0; ack = 1'b0; game_end = 1'b0; switches = 6'd0;
        applyReset();
        checkOutput("rst_addr", {26'd0, addr}, 0);
        checkOutput("rst_enable", {31'd0, enable}, 0);
        checkOutput("rst_player", {31'd0, player}, 0);
        checkOutput("rst_rejected", {31'd0, rejected}, 0);
        checkOutput("rst_over", {31'd0, over}, 0);
        checkOutput("rst_init_busy", {31'd0, init_busy}, 1);
        checkOutput("rst_init_addr", {25'd0, init_addr}, 0);
        runInit("init");
        expPlayer = 1'b0;

        for (int i = 0; i < 6; i++) begin
            doMove($sformatf("tab%0d", i), moveTab[i].sw, moveTab[i].ackAt,
                   moveTab[i].expEn, moveTab[i].expRej, moveTab[i].toggle);
        end

        // go held high across an accepted move must start only one move
        @(negedge clock);
        switches = 6'o21;
        go       = 1'b1;
        entries  = 0;
        prevEn   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (enable && !prevEn) entries++;
            prevEn = enable;
            ack    = (i == 3);
            @(negedge clock);
        end
        ack = 1'b0;
        go  = 1'b0;
        expPlayer = ~expPlayer;
        checkOutput("held_entries", entries, 1);
        checkOutput("held_player", {31'd0, player}, {31'd0, expPlayer});
        checkOutput("held_addr", {26'd0, addr}, 17);

        for (int r = 0; r < 8; r++) begin
            sw    = 6'($urandom_range(63));
            ackAt = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(15, 1));
            if (ackAt >= 1 && ackAt <= TIMEOUT) begin
                expEn  = ackAt;
                expRej = 0;
            end else begin
                expEn  = TIMEOUT;
                expRej = 1;
            end
            doMove($sformatf("rnd%0d", r), sw, ackAt, expEn, expRej, expRej == 0);
            repeat ($urandom_range(3)) @(negedge clock);
        end

        // reset in the middle of the board load restarts it from index 0
        applyReset();
        checkOutput("rst2_player", {31'd0, player}, 0);
        checkOutput("rst2_addr", {26'd0, addr}, 0);
        reset = 1'b0;
        n = 0;
        while (init_addr !== 7'd50 && n < 120) begin
            @(negedge clock);
            n++;
        end
        checkOutput("reach_idx50", {25'd0, init_addr}, 50);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("restart_addr", {25'd0, init_addr}, 0);
        runInit("reinit");
        expPlayer = 1'b0;

        // ack and game_end together: game ends, no toggle, later go ignored
        @(negedge clock);
        switches = 6'o07;
        go       = 1'b1;
        @(negedge clock);
        go = 1'b0;
        @(negedge clock);
        ack      = 1'b1;
        game_end = 1'b1;
        @(negedge clock);
        ack      = 1'b0;
        game_end = 1'b0;
        checkOutput("end_over", {31'd0, over}, 1);
        checkOutput("end_enable", {31'd0, enable}, 0);
        checkOutput("end_player", {31'd0, player}, {31'd0, expPlayer});
        go       = 1'b1;
        switches = 6'o70;
        @(negedge clock);
        go     = 1'b0;
        enHigh = 0;
        for (int i = 0; i < 5; i++) begin
            if (enable) enHigh++;
            @(negedge clock);
        end
        checkOutput("end_go_ignored", enHigh, 0);
        checkOutput("end_addr_held", {26'd0, addr}, 7);
        checkOutput("end_over_held", {31'd0, over}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/othello_control.md
OTHELLO_CONTROL -- requirements
Module: othello_control

Interface
REQ-001 Parameter TIMEOUT, default 200, cycles allowed for datapath ack before the move counts as rejected.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 go  input  1  player "place" key, already synchronized, active high, level.
REQ-005 switches  input  6  move address {row[2:0], col[2:0]}, 0..63.
REQ-006 ack  input  1  datapath valid-move acknowledge, single-cycle pulse.
REQ-007 game_end  input  1  datapath end-of-game flag.
REQ-008 addr  output  6  latched move address to datapath.
REQ-009 enable  output  1  datapath operate request.
REQ-010 player  output  1  side to move: 0 black, 1 white.
REQ-011 init_addr  output  7  board memory address during initialisation.
REQ-012 init_data  output  2  cell code written during initialisation.
REQ-013 init_wren  output  1  memory write enable during initialisation.
REQ-014 init_busy  output  1  high while this block owns the memory port; selects init_* over datapath signals.
REQ-015 rejected  output  1  one-cycle pulse when a move times out.
REQ-016 over  output  1  high once the game has ended.

Function
REQ-017 States: INIT, WAIT_GO, RUN, END; encoding defined in shared package.
REQ-018 Board memory is 10x10 padded, cell index = 10*row + col, rows/cols 0..9; move address maps to index 10*(row+1)+(col+1) inside the datapath, not here.
REQ-019 Cell codes: 00 empty, 01 black, 10 white, 11 wall.
REQ-020 INIT writes indices 0..99 in ascending order, one per cycle, init_wren=1, init_busy=1, 100 cycles total.
REQ-021 INIT data: 11 if row or col is 0 or 9; 10 at (4,4),(5,5); 01 at (4,5),(5,4); else 00.
REQ-022 Row/col tracked with counters (col wraps 9->0, row increments); no divider.
REQ-023 Cycle after index 99 written: init_wren=0, init_busy=0, state WAIT_GO.
REQ-024 WAIT_GO: rising edge of go (go=1, previous go=0) latches switches into addr, enters RUN next cycle; go held high does not retrigger.
REQ-025 go edges outside WAIT_GO are ignored; the edge detector still tracks go in every state.
REQ-026 RUN: enable=1 every cycle; 8-bit timeout counter cleared on entry, increments each cycle.
REQ-027 RUN, ack=1: enable drops next cycle, player toggles, state WAIT_GO.
REQ-028 RUN, counter reaches TIMEOUT-1 without ack: rejected pulses one cycle, player unchanged, state WAIT_GO.
REQ-029 ack and timeout in same cycle: ack wins, no rejected pulse.
REQ-030 game_end=1 in RUN or WAIT_GO: state END next cycle; overrides ack and timeout; player not toggled.
REQ-031 END: enable=0, over=1, all inputs ignored until reset.
REQ-032 addr holds its value outside the latch event.

Reset
REQ-033 reset forces state INIT, index/row/col counters 0, player=0, addr=0, enable=0, rejected=0, over=0, timeout counter 0, previous-go register 0.
REQ-034 reset asserted mid-INIT restarts initialisation at index 0; mid-RUN drops enable next edge.
REQ-035 init_busy=1 and init_wren=1 from the first cycle after reset release.

Structure
REQ-036 Package othello_pkg holds cell codes, BOARD_DIM=10, BOARD_CELLS=100, and the state encoding; shared with datapath.
REQ-037 One sub-module board_init_gen: combinational row/col -> init_data mapper per REQ-021.

Verification
REQ-038 Reset then 100 cycles -> writes observed: idx0=11, idx44=10, idx45=01, idx54=01, idx55=10, idx11=00, idx99=11; init_busy low at cycle 101.
REQ-039 WAIT_GO, switches=6'o34, go pulse, ack after 5 cycles -> addr=28, enable high 6 cycles, player 0->1.
REQ-040 go pulse, no ack -> enable high TIMEOUT cycles, rejected one pulse, player unchanged, state WAIT_GO.
REQ-041 go held high 50 cycles across an accepted move -> only one RUN entry.
REQ-042 ack and game_end same cycle in RUN -> over=1, player unchanged, later go ignored.
REQ-043 reset at init index 50 -> init_addr restarts at 0, full 100 writes follow.
